// File: rtl/deco_temp_histeresis_if.sv
// Sample bus between the temperature sensor front end and the alarm decoder.
// The master drives samples and the peak clear; the slave returns the flags.
interface deco_temp_histeresis_if #(
  parameter int W = 3
);
  logic         muestra_valida;
  logic [W-1:0] temp;
  logic         borrar_max;
  logic         temp_alta;
  logic         cambio;
  logic [W-1:0] temp_max;

  modport master (
    output muestra_valida,
    output temp,
    output borrar_max,
    input  temp_alta,
    input  cambio,
    input  temp_max
  );

  modport slave (
    input  muestra_valida,
    input  temp,
    input  borrar_max,
    output temp_alta,
    output cambio,
    output temp_max
  );
endinterface

// File: rtl/deco_temp_histeresis.sv
// High-temperature alarm decoder with hysteresis band, sample persistence,
// a one-cycle change pulse and a clearable peak register.
//
// state     | meaning
// NORMAL    | temperature normal, temp_alta = 0
// CONF_ALTA | counting consecutive hot samples, temp_alta = 0
// ALTA      | temperature high, temp_alta = 1
// CONF_BAJA | counting consecutive cool samples, temp_alta = 1
module deco_temp_histeresis #(
  parameter int W           = 3,
  parameter int UMBRAL_ALTO = 3,
  parameter int UMBRAL_BAJO = 1,
  parameter int N_MUESTRAS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  deco_temp_histeresis_if.slave bus
);

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    CONF_ALTA = 2'd1,
    ALTA      = 2'd2,
    CONF_BAJA = 2'd3
  } estado_t;

  localparam logic [W-1:0] U_ALTO = W'(UMBRAL_ALTO);
  localparam logic [W-1:0] U_BAJO = W'(UMBRAL_BAJO);
  localparam logic [7:0]   N_CNT  = 8'(N_MUESTRAS);
  localparam bit           N_UNO  = (N_MUESTRAS == 1);

  estado_t      estado_q, estado_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         alta_q, alta_d;
  logic         cambio_q;
  logic [W-1:0] max_q;
  logic         caliente, fria;

  // Mid-band samples are neither hot nor cool, so they only break a run.
  assign caliente = (bus.temp >= U_ALTO);
  assign fria     = (bus.temp <= U_BAJO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= NORMAL;
      cnt_q    <= 8'd0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    if (bus.muestra_valida) begin
      case (estado_q)
        NORMAL: begin
          if (caliente) begin
            cnt_d    = 8'd1;
            estado_d = N_UNO ? ALTA : CONF_ALTA;
          end
        end
        CONF_ALTA: begin
          if (!caliente) begin
            estado_d = NORMAL;
            cnt_d    = 8'd0;
          end else if (cnt_q + 8'd1 == N_CNT) begin
            estado_d = ALTA;
            cnt_d    = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ALTA: begin
          if (fria) begin
            cnt_d    = 8'd1;
            estado_d = N_UNO ? NORMAL : CONF_BAJA;
          end
        end
        CONF_BAJA: begin
          if (!fria) begin
            estado_d = ALTA;
            cnt_d    = 8'd0;
          end else if (cnt_q + 8'd1 == N_CNT) begin
            estado_d = NORMAL;
            cnt_d    = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          estado_d = NORMAL;
          cnt_d    = 8'd0;
        end
      endcase
    end
  end

  // Flag and pulse are decoded from the next state so both appear together
  // on the cycle after the deciding sample, with no path from temp.
  assign alta_d = (estado_d == ALTA) || (estado_d == CONF_BAJA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alta_q   <= 1'b0;
      cambio_q <= 1'b0;
    end else begin
      alta_q   <= alta_d;
      cambio_q <= alta_d ^ alta_q;
    end
  end

  // A clear with a simultaneous valid sample restarts the peak from that sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else if (bus.borrar_max) begin
      max_q <= bus.muestra_valida ? bus.temp : '0;
    end else if (bus.muestra_valida && (bus.temp > max_q)) begin
      max_q <= bus.temp;
    end
  end

  assign bus.temp_alta = alta_q;
  assign bus.cambio    = cambio_q;
  assign bus.temp_max  = max_q;

endmodule

// File: tb/tb_deco_temp_histeresis.sv
// Directed bench for the temperature alarm decoder (W=3, hot>=3, cool<=1, N=4).
module tb_deco_temp_histeresis;
  localparam int W = 3;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  deco_temp_histeresis_if #(.W(W)) bus ();

  deco_temp_histeresis #(
    .W(W), .UMBRAL_ALTO(3), .UMBRAL_BAJO(1), .N_MUESTRAS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic alta, input logic cam, input logic [W-1:0] mx);
    chk({tag, ".temp_alta"}, {7'd0, bus.temp_alta}, {7'd0, alta});
    chk({tag, ".cambio"}, {7'd0, bus.cambio}, {7'd0, cam});
    chk({tag, ".temp_max"}, {5'd0, bus.temp_max}, {5'd0, mx});
  endtask

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic paso(input logic v, input logic [W-1:0] t, input logic b);
    bus.muestra_valida = v;
    bus.temp           = t;
    bus.borrar_max     = b;
    @(posedge clk);
    #1;
    bus.muestra_valida = 1'b0;
    bus.borrar_max     = 1'b0;
    bus.temp           = 3'd7;
  endtask

  task automatic muestra(input logic [W-1:0] t);
    paso(1'b1, t, 1'b0);
  endtask

  task automatic hueco(input int n);
    for (int i = 0; i < n; i++) paso(1'b0, 3'd7, 1'b0);
  endtask

  initial begin
    reset              = 1'b1;
    bus.muestra_valida = 1'b0;
    bus.temp           = '0;
    bus.borrar_max     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    // Rise: four hot samples of 5
    for (int i = 0; i < 3; i++) begin
      muestra(3'd5);
      chk_out("rise_pre", 1'b0, 1'b0, 3'd5);
    end
    muestra(3'd5);
    chk_out("rise_4th", 1'b1, 1'b1, 3'd5);
    hueco(1);
    chk_out("rise_hold", 1'b1, 1'b0, 3'd5);

    // Fall: 1,1,2,1,1,1,1 -- the 2 breaks the run
    muestra(3'd1); chk_out("fall_1", 1'b1, 1'b0, 3'd5);
    muestra(3'd1); chk_out("fall_2", 1'b1, 1'b0, 3'd5);
    muestra(3'd2); chk_out("fall_brk", 1'b1, 1'b0, 3'd5);
    for (int i = 0; i < 3; i++) begin
      muestra(3'd1);
      chk_out("fall_run", 1'b1, 1'b0, 3'd5);
    end
    muestra(3'd1);
    chk_out("fall_4th", 1'b0, 1'b1, 3'd5);
    hueco(1);
    chk_out("fall_hold", 1'b0, 1'b0, 3'd5);

    // Mid-band in NORMAL, then rise with 7s, then mid-band in ALTA
    for (int i = 0; i < 6; i++) begin
      muestra(3'd2);
      chk_out("mid_normal", 1'b0, 1'b0, 3'd5);
    end
    for (int i = 0; i < 3; i++) muestra(3'd7);
    chk_out("rise7_pre", 1'b0, 1'b0, 3'd7);
    muestra(3'd7);
    chk_out("rise7_4th", 1'b1, 1'b1, 3'd7);
    for (int i = 0; i < 6; i++) begin
      muestra(3'd2);
      chk_out("mid_alta", 1'b1, 1'b0, 3'd7);
    end
    for (int i = 0; i < 3; i++) muestra(3'd0);
    chk_out("fall0_pre", 1'b1, 1'b0, 3'd7);
    muestra(3'd0);
    chk_out("fall0_4th", 1'b0, 1'b1, 3'd7);

    // Threshold-value hot samples (3) separated by invalid gaps of 0,3,5
    muestra(3'd3);
    muestra(3'd3);
    hueco(3);
    muestra(3'd3);
    hueco(5);
    chk_out("gap_pre", 1'b0, 1'b0, 3'd7);
    muestra(3'd3);
    chk_out("gap_4th", 1'b1, 1'b1, 3'd7);
    for (int i = 0; i < 4; i++) muestra(3'd1);
    chk_out("gap_fall", 1'b0, 1'b1, 3'd7);

    // Peak register
    paso(1'b0, 3'd7, 1'b1); chk_out("max_clr", 1'b0, 1'b0, 3'd0);
    muestra(3'd3); chk_out("max_3", 1'b0, 1'b0, 3'd3);
    muestra(3'd6); chk_out("max_6", 1'b0, 1'b0, 3'd6);
    muestra(3'd2); chk_out("max_2", 1'b0, 1'b0, 3'd6);
    muestra(3'd7); chk_out("max_7", 1'b0, 1'b0, 3'd7);
    muestra(3'd4); chk_out("max_4", 1'b0, 1'b0, 3'd7);
    paso(1'b0, 3'd7, 1'b1); chk_out("max_clr2", 1'b0, 1'b0, 3'd0);
    paso(1'b1, 3'd2, 1'b1); chk_out("max_clr_ld", 1'b0, 1'b0, 3'd2);
    muestra(3'd6); chk_out("max_6b", 1'b0, 1'b0, 3'd6);
    paso(1'b1, 3'd2, 1'b1); chk_out("max_clr_ld2", 1'b0, 1'b0, 3'd2);
    hueco(2); chk_out("max_invalid", 1'b0, 1'b0, 3'd2);

    // Reset mid-confirmation
    for (int i = 0; i < 3; i++) muestra(3'd4);
    chk_out("conf_pre_rst", 1'b0, 1'b0, 3'd4);
    reset = 1'b1;
    #2;
    chk_out("async_rst", 1'b0, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      muestra(3'd4);
      chk_out("post_rst_pre", 1'b0, 1'b0, 3'd4);
    end
    muestra(3'd4);
    chk_out("post_rst_4th", 1'b1, 1'b1, 3'd4);
    hueco(1);
    chk_out("post_rst_hold", 1'b1, 1'b0, 3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
